// File: rtl/rxepktgate_pkg.sv
// Shared receive-path definitions: read-side state encoding and default runt threshold.
package rxepktgate_pkg;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_SEND  = 2'd2
  } rd_state_t;

  localparam int MINLEN_DEFAULT = 60;

endpackage

// File: rtl/rxepktgate_lenfifo.sv
// Synchronous FIFO of committed packet lengths with show-ahead read data.
module rxelenfifo #(
  parameter int DW  = 13,
  parameter int LGD = 3
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty
);

  localparam logic [LGD:0] DEPTH = (LGD+1)'(2**LGD);

  logic [DW-1:0]  mem [2**LGD];
  logic [LGD-1:0] wr_idx;
  logic [LGD-1:0] rd_idx;
  logic [LGD:0]   count;
  logic           push;
  logic           pop;

  assign o_full  = (count == DEPTH);
  assign o_empty = (count == '0);
  assign pop     = i_rd && !o_empty;
  // a push into a full FIFO is only accepted when a pop frees the slot
  assign push    = i_wr && (!o_full || pop);
  assign o_rdata = mem[rd_idx];

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_idx] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_idx <= wr_idx + 1'b1;
      if (pop)
        rd_idx <= rd_idx + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rxepktgate.sv
// Receive packet gate: buffers each packet, then commits it for replay or discards it.
//   state    | meaning
//   RD_IDLE  | no committed packet being replayed; waits for a queued length
//   RD_FETCH | memory read of the first byte of a packet in flight
//   RD_SEND  | byte presented on o_data; advances on i_ready
module rxepktgate
  import rxepktgate_pkg::*;
#(
  parameter int LGMEM  = 12,
  parameter int LGLEN  = 3,
  parameter int MINLEN = MINLEN_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_v,
  input  logic [7:0] i_d,
  input  logic       i_err,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_last,
  input  logic       i_ready,
  output logic       o_commit,
  output logic       o_drop,
  output logic       o_ovfl
);

  localparam logic [LGMEM:0] LEN_MIN = (LGMEM+1)'(MINLEN);
  localparam logic [LGMEM:0] LEN_CAP = {1'b0, {LGMEM{1'b1}}};
  localparam logic [LGMEM:0] REM_ONE = (LGMEM+1)'(1);

  logic [7:0]       mem [2**LGMEM];
  logic [LGMEM-1:0] wr_ptr;
  logic [LGMEM-1:0] cmt_ptr;
  logic [LGMEM-1:0] rd_ptr;
  logic [LGMEM-1:0] rd_addr;
  logic [LGMEM:0]   len;
  logic [LGMEM:0]   rd_rem;
  logic [7:0]       rd_data;
  logic             pkt_err;
  logic             pkt_ovfl;
  logic             v_q;
  logic             skip;
  logic             active;
  logic             first;
  logic             end_cyc;
  logic             ovfl_now;
  logic             wr_en;
  logic             do_commit;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [LGMEM:0]   fifo_head;
  logic             accept;
  logic             rd_en;
  rd_state_t        state;
  rd_state_t        state_nxt;

  // write side
  always_comb begin
    active    = i_v && !skip;
    first     = active && !v_q;
    end_cyc   = v_q && !i_v;
    ovfl_now  = pkt_ovfl || (first && fifo_full) ||
                ((wr_ptr + 1'b1) == rd_ptr) || (len >= LEN_CAP);
    wr_en     = active && !ovfl_now;
    // the error flag arrives one cycle late, so the end cycle still contributes
    do_commit = end_cyc && !(pkt_err || i_err) && !pkt_ovfl && (len >= LEN_MIN);
  end

  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wr_ptr] <= i_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      len      <= '0;
      pkt_err  <= 1'b0;
      pkt_ovfl <= 1'b0;
      v_q      <= 1'b0;
      skip     <= i_v;
      o_commit <= 1'b0;
      o_drop   <= 1'b0;
      o_ovfl   <= 1'b0;
    end else begin
      o_commit <= 1'b0;
      o_drop   <= 1'b0;
      o_ovfl   <= 1'b0;
      v_q      <= active;
      if (!i_v)
        skip <= 1'b0;
      if (active) begin
        pkt_err <= pkt_err | i_err;
        if (ovfl_now)
          pkt_ovfl <= 1'b1;
        if (len != '1)
          len <= len + 1'b1;
        if (wr_en)
          wr_ptr <= wr_ptr + 1'b1;
      end else if (end_cyc) begin
        pkt_err  <= 1'b0;
        pkt_ovfl <= 1'b0;
        len      <= '0;
        if (do_commit) begin
          cmt_ptr  <= wr_ptr;
          o_commit <= 1'b1;
        end else begin
          wr_ptr <= cmt_ptr;
          o_drop <= 1'b1;
          o_ovfl <= pkt_ovfl;
        end
      end
    end
  end

  rxelenfifo #(
    .DW  (LGMEM + 1),
    .LGD (LGLEN)
  ) u_lenfifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr    (do_commit),
    .i_wdata (len),
    .i_rd    (fifo_pop),
    .o_rdata (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // read side
  always_comb begin
    state_nxt = state;
    fifo_pop  = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = rd_ptr;
    accept    = (state == RD_SEND) && i_ready;
    case (state)
      RD_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = RD_FETCH;
        end
      end
      RD_FETCH: begin
        rd_en     = 1'b1;
        state_nxt = RD_SEND;
      end
      RD_SEND: begin
        if (i_ready) begin
          // packets are contiguous, so the prefetch also serves the next packet
          rd_en   = 1'b1;
          rd_addr = rd_ptr + 1'b1;
          if (rd_rem == REM_ONE) begin
            if (!fifo_empty)
              fifo_pop = 1'b1;
            else
              state_nxt = RD_IDLE;
          end
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= RD_IDLE;
      rd_ptr <= '0;
      rd_rem <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        rd_ptr <= rd_ptr + 1'b1;
      if (fifo_pop)
        rd_rem <= fifo_head;
      else if (accept)
        rd_rem <= rd_rem - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[rd_addr];
  end

  assign o_valid = (state == RD_SEND);
  assign o_last  = o_valid && (rd_rem == REM_ONE);
  assign o_data  = rd_data;

endmodule

// File: tb/tb_rxepktgate.sv
// Scoreboard bench for rxepktgate: a default instance plus a 64-byte-buffer instance for overflow.
module tb_rxepktgate;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v = 1'b0;
  logic [7:0] d = '0;
  logic       err = 1'b0;
  logic       ready = 1'b1;
  logic       sel = 1'b0;

  logic       b_valid, b_last, b_commit, b_drop, b_ovfl;
  logic [7:0] b_data;
  logic       s_valid, s_last, s_commit, s_drop, s_ovfl;
  logic [7:0] s_data;

  logic       mv, ml, mc, md, mo;
  logic [7:0] mdat;

  int n_checks = 0;
  int n_fail = 0;
  int cnt_commit = 0;
  int cnt_drop = 0;
  int cnt_ovfl = 0;
  bit mon_en = 0;
  bit prev_hold = 0;
  logic [9:0] prev_vec = '0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_b;

  always #5 clk = ~clk;

  rxepktgate dut (
    .i_clk(clk), .i_reset(rst), .i_v(v && !sel), .i_d(d), .i_err(err),
    .o_valid(b_valid), .o_data(b_data), .o_last(b_last), .i_ready(ready),
    .o_commit(b_commit), .o_drop(b_drop), .o_ovfl(b_ovfl)
  );

  rxepktgate #(.LGMEM(6), .LGLEN(3), .MINLEN(60)) dut_s (
    .i_clk(clk), .i_reset(rst), .i_v(v && sel), .i_d(d), .i_err(err),
    .o_valid(s_valid), .o_data(s_data), .o_last(s_last), .i_ready(ready),
    .o_commit(s_commit), .o_drop(s_drop), .o_ovfl(s_ovfl)
  );

  assign mv   = sel ? s_valid  : b_valid;
  assign ml   = sel ? s_last   : b_last;
  assign mdat = sel ? s_data   : b_data;
  assign mc   = sel ? s_commit : b_commit;
  assign md   = sel ? s_drop   : b_drop;
  assign mo   = sel ? s_ovfl   : b_ovfl;

  // output monitor: pulse counting, hold-stable check and scoreboard pops
  always @(negedge clk) begin
    if (mon_en) begin
      if (mc) cnt_commit++;
      if (md) cnt_drop++;
      if (mo) cnt_ovfl++;
      if (prev_hold) begin
        n_checks++;
        if ({mv, ml, mdat} !== prev_vec) begin
          n_fail++;
          $display("FAIL hold_stable: got v/l/d %b/%b/%h, expected %b/%b/%h",
                   mv, ml, mdat, prev_vec[9], prev_vec[8], prev_vec[7:0]);
        end
      end
      if (mv && ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_byte: got data %h last %b, expected no output", mdat, ml);
        end else begin
          exp_b = exp_q.pop_front();
          if ({ml, mdat} !== exp_b) begin
            n_fail++;
            $display("FAIL stream_byte: got data %h last %b, expected data %h last %b",
                     mdat, ml, exp_b[7:0], exp_b[8]);
          end
        end
      end
      prev_hold = mv && !ready;
      prev_vec  = {mv, ml, mdat};
    end
  end

  task automatic send_pkt(input int n, input int base, input bit err_end, input bit push_exp);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      v = 1'b1; d = 8'(base + i); err = 1'b0;
      if (push_exp) exp_q.push_back({(i == n - 1), 8'(base + i)});
    end
    @(posedge clk); #1;
    v = 1'b0; d = '0; err = err_end;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !mv) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (5) @(negedge clk);
    err = 1'b0;
  endtask

  task automatic clear_counts();
    cnt_commit = 0; cnt_drop = 0; cnt_ovfl = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", b_valid); end
    n_checks++; if (b_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", b_data); end
    n_checks++; if (b_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", b_last); end
    n_checks++; if ({b_commit, b_drop, b_ovfl} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {b_commit, b_drop, b_ovfl}); end
    n_checks++; if ({s_valid, s_last, s_commit, s_drop, s_ovfl, s_data} !== 13'h0) begin n_fail++; $display("FAIL reset_small: got %h expected 0", {s_valid, s_last, s_commit, s_drop, s_ovfl, s_data}); end
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_clean();
    bit ok;
    sel = 1'b0; ready = 1'b1; clear_counts();
    send_pkt(64, 0, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if (b_commit !== 1'b0) begin n_fail++; $display("FAIL clean_commit_early: got %b expected 0", b_commit); end
    @(negedge clk);
    n_checks++; if (b_commit !== 1'b1) begin n_fail++; $display("FAIL clean_commit_pulse: got %b expected 1", b_commit); end
    n_checks++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL clean_valid_e1: got %b expected 0", b_valid); end
    @(negedge clk);
    n_checks++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL clean_valid_e2: got %b expected 0", b_valid); end
    @(negedge clk);
    n_checks++; if (b_valid !== 1'b1) begin n_fail++; $display("FAIL clean_latency: got valid %b expected 1", b_valid); end
    wait_idle(500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL clean_drain: got %0d bytes left expected 0", exp_q.size()); end
    n_checks++; if (cnt_commit !== 1 || cnt_drop !== 0) begin n_fail++; $display("FAIL clean_counts: got commit %0d drop %0d expected 1 0", cnt_commit, cnt_drop); end
  endtask

  task automatic test_late_error();
    bit ok;
    sel = 1'b0; ready = 1'b1; clear_counts();
    send_pkt(64, 8'h40, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (b_drop !== 1'b1) begin n_fail++; $display("FAIL late_err_drop: got %b expected 1", b_drop); end
    n_checks++; if (b_ovfl !== 1'b0) begin n_fail++; $display("FAIL late_err_ovfl: got %b expected 0", b_ovfl); end
    n_checks++; if (b_commit !== 1'b0) begin n_fail++; $display("FAIL late_err_commit: got %b expected 0", b_commit); end
    repeat (10) @(negedge clk);
    send_pkt(64, 8'h80, 1'b0, 1'b1);
    wait_idle(500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL late_err_drain: got %0d bytes left expected 0", exp_q.size()); end
    n_checks++; if (cnt_commit !== 1 || cnt_drop !== 1) begin n_fail++; $display("FAIL late_err_counts: got commit %0d drop %0d expected 1 1", cnt_commit, cnt_drop); end
  endtask

  task automatic test_runt();
    bit ok;
    sel = 1'b0; ready = 1'b1; clear_counts();
    send_pkt(59, 8'h10, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    n_checks++; if (cnt_drop !== 1 || cnt_commit !== 0) begin n_fail++; $display("FAIL runt_59: got commit %0d drop %0d expected 0 1", cnt_commit, cnt_drop); end
    send_pkt(60, 8'h20, 1'b0, 1'b1);
    wait_idle(500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL runt_drain: got %0d bytes left expected 0", exp_q.size()); end
    n_checks++; if (cnt_commit !== 1 || cnt_drop !== 1) begin n_fail++; $display("FAIL runt_60: got commit %0d drop %0d expected 1 1", cnt_commit, cnt_drop); end
  endtask

  task automatic test_overflow();
    bit ok;
    sel = 1'b1; ready = 1'b0; clear_counts();
    send_pkt(70, 0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (s_drop !== 1'b1) begin n_fail++; $display("FAIL ovfl_drop: got %b expected 1", s_drop); end
    n_checks++; if (s_ovfl !== 1'b1) begin n_fail++; $display("FAIL ovfl_flag: got %b expected 1", s_ovfl); end
    repeat (5) @(negedge clk);
    ready = 1'b1;
    send_pkt(60, 8'hA0, 1'b0, 1'b1);
    wait_idle(500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovfl_drain: got %0d bytes left expected 0", exp_q.size()); end
    n_checks++; if (cnt_commit !== 1 || cnt_drop !== 1 || cnt_ovfl !== 1) begin n_fail++; $display("FAIL ovfl_counts: got commit %0d drop %0d ovfl %0d expected 1 1 1", cnt_commit, cnt_drop, cnt_ovfl); end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    sel = 1'b0; ready = 1'b1; clear_counts();
    fork
      begin
        send_pkt(60, 0, 1'b0, 1'b1);
        send_pkt(60, 60, 1'b0, 1'b1);
        send_pkt(60, 120, 1'b0, 1'b1);
      end
      begin
        for (int c = 0; c < 400; c++) begin
          @(posedge clk); #1;
          ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1;
    ready = 1'b1;
    wait_idle(2000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_drain: got %0d bytes left expected 0", exp_q.size()); end
    n_checks++; if (cnt_commit !== 3 || cnt_drop !== 0) begin n_fail++; $display("FAIL b2b_counts: got commit %0d drop %0d expected 3 0", cnt_commit, cnt_drop); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    sel = 1'b0; ready = 1'b1; clear_counts();
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      rst = (i == 30);
      v = 1'b1; d = 8'(i); err = 1'b0;
      if (i == 31) begin
        n_checks++;
        if ({b_valid, b_last, b_commit, b_drop, b_ovfl, b_data} !== 13'h0) begin
          n_fail++;
          $display("FAIL reset_mid_outputs: got %h expected 0", {b_valid, b_last, b_commit, b_drop, b_ovfl, b_data});
        end
      end
    end
    @(posedge clk); #1;
    v = 1'b0; d = '0;
    repeat (10) @(negedge clk);
    n_checks++; if (cnt_commit !== 0) begin n_fail++; $display("FAIL reset_mid_commit: got %0d expected 0", cnt_commit); end
    n_checks++; if (cnt_drop !== 0) begin n_fail++; $display("FAIL reset_mid_drop: got %0d expected 0", cnt_drop); end
    send_pkt(60, 8'h33, 1'b0, 1'b1);
    wait_idle(500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL reset_mid_drain: got %0d bytes left expected 0", exp_q.size()); end
    n_checks++; if (cnt_commit !== 1 || cnt_drop !== 0) begin n_fail++; $display("FAIL reset_mid_after: got commit %0d drop %0d expected 1 0", cnt_commit, cnt_drop); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_late_error();
    test_runt();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: got %0d pending bytes expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
